// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared codes, address field layout and lane-op helper for the MMIO output bank
package mmio_pkg;

  // RISC-V load width codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RISC-V store width codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Store operation selected by address bits [11:10]
  typedef enum logic [1:0] {
    OP_WR  = 2'b00,
    OP_SET = 2'b01,
    OP_CLR = 2'b10,
    OP_TGL = 2'b11
  } op_e;

  // Address field positions
  localparam int CH_LSB  = 12;
  localparam int CH_W    = 4;
  localparam int OP_LSB  = 10;
  localparam int OP_W    = 2;
  localparam int OFS_LSB = 0;
  localparam int OFS_W   = 2;

  // Apply a read-modify-write op to the enabled byte lanes of a register
  function automatic logic [31:0] apply_op(input op_e op, input logic [31:0] r,
                                           input logic [31:0] d, input logic [3:0] be);
    logic [31:0] n;
    logic [31:0] res;
    case (op)
      OP_WR:   n = d;
      OP_SET:  n = r | d;
      OP_CLR:  n = r & ~d;
      OP_TGL:  n = r ^ d;
      default: n = r;
    endcase
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? n[8*i +: 8] : r[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mmio_lane_align.sv
// rtl/mmio_lane_align.sv - byte-lane enables, store data alignment and load extraction
module mmio_lane_align
  import mmio_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  func3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_al,
  output logic [31:0] rdata_ext,
  output logic        illegal
);

  logic [4:0]  shamt;
  logic [31:0] rshift;

  assign shamt    = {offset, 3'b000};
  assign wdata_al = wdata << shamt;
  assign rshift   = rword >> shamt;

  // Legality and lane selection depend on access width and offset alignment
  always_comb begin
    byte_en = 4'b0000;
    illegal = 1'b1;
    if (is_store) begin
      case (func3)
        F3_SB: begin
          byte_en = 4'b0001 << offset;
          illegal = 1'b0;
        end
        F3_SH: begin
          byte_en = 4'b0011 << offset;
          illegal = offset[0];
        end
        F3_SW: begin
          byte_en = 4'b1111;
          illegal = (offset != 2'd0);
        end
        default: illegal = 1'b1;
      endcase
    end else begin
      case (func3)
        F3_LB, F3_LBU: illegal = 1'b0;
        F3_LH, F3_LHU: illegal = offset[0];
        F3_LW:         illegal = (offset != 2'd0);
        default:       illegal = 1'b1;
      endcase
    end
  end

  // Pull the addressed lane down to bit 0 and extend it; illegal loads read as zero
  always_comb begin
    rdata_ext = 32'd0;
    if (!illegal) begin
      case (func3)
        F3_LB:   rdata_ext = {{24{rshift[7]}}, rshift[7:0]};
        F3_LBU:  rdata_ext = {24'd0, rshift[7:0]};
        F3_LH:   rdata_ext = {{16{rshift[15]}}, rshift[15:0]};
        F3_LHU:  rdata_ext = {16'd0, rshift[15:0]};
        F3_LW:   rdata_ext = rshift;
        default: rdata_ext = 32'd0;
      endcase
    end
  end

endmodule

// File: rtl/mmio_out_bank.sv
// rtl/mmio_out_bank.sv - bank of 32-bit MMIO output channels with byte-lane RMW ops; OUTBUF_BLINK_EN adds a blink mask
module mmio_out_bank
  import mmio_pkg::*;
#(
  parameter int NUM_CH    = 5,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wren,
  input  logic                  i_rden,
  input  logic [2:0]            i_func3,
  input  logic [31:0]           i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata,
  output logic                  o_rvalid,
  output logic                  o_misalign,
  output logic [NUM_CH*32-1:0]  o_ch_data,
  output logic                  o_blink_phase
);

  localparam logic [3:0] NUM_CH_C = 4'(NUM_CH);

  logic [CH_W-1:0]  ch;
  op_e              op;
  logic [OFS_W-1:0] ofs;
  logic             ch_hit;
  logic             mask_hit;
  logic             mapped;

  logic [3:0]       st_be;
  logic [31:0]      st_data;
  logic             st_illegal;
  logic             st_fire;
  logic [31:0]      ld_word;
  logic [31:0]      ld_ext;
  logic             ld_illegal;

  logic [NUM_CH*32-1:0] ch_flat;
  logic [31:0]          blink_kill;

  logic [31:0] st_unused_rdata;
  logic [3:0]  ld_unused_be;
  logic [31:0] ld_unused_wd;
  logic        unused_addr;

  assign ch  = i_addr[CH_LSB +: CH_W];
  assign op  = op_e'(i_addr[OP_LSB +: OP_W]);
  assign ofs = i_addr[OFS_LSB +: OFS_W];
  assign unused_addr = ^{i_addr[31:16], i_addr[9:2]};

  assign ch_hit  = (ch < NUM_CH_C);
  assign mapped  = ch_hit | mask_hit;
  assign st_fire = i_wren & mapped & ~st_illegal;

  mmio_lane_align u_store_align (
    .is_store  (1'b1),
    .func3     (i_func3),
    .offset    (ofs),
    .wdata     (i_wdata),
    .rword     (32'd0),
    .byte_en   (st_be),
    .wdata_al  (st_data),
    .rdata_ext (st_unused_rdata),
    .illegal   (st_illegal)
  );

  mmio_lane_align u_load_align (
    .is_store  (1'b0),
    .func3     (i_func3),
    .offset    (ofs),
    .wdata     (32'd0),
    .rword     (ld_word),
    .byte_en   (ld_unused_be),
    .wdata_al  (ld_unused_wd),
    .rdata_ext (ld_ext),
    .illegal   (ld_illegal)
  );

`ifdef OUTBUF_BLINK_EN
  localparam int              CNT_W    = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic [31:0]      mask_q;
  logic [CNT_W-1:0] blink_cnt;

  assign mask_hit   = (ch == NUM_CH_C);
  assign blink_kill = mask_q & {32{o_blink_phase}};

  // Blink mask register shares the channel op and lane semantics
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mask_q <= 32'd0;
    end else if (st_fire && mask_hit) begin
      mask_q <= apply_op(op, mask_q, st_data, st_be);
    end
  end

  // Free-running half-period counter; phase flips each time it wraps
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      blink_cnt     <= '0;
      o_blink_phase <= 1'b0;
    end else if (blink_cnt == CNT_LAST) begin
      blink_cnt     <= '0;
      o_blink_phase <= ~o_blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end
`else
  logic unused_blink_div;

  assign mask_hit         = 1'b0;
  assign blink_kill       = 32'd0;
  assign o_blink_phase    = 1'b0;
  assign unused_blink_div = (BLINK_DIV < 2);
`endif

  // Select the addressed register word for loads; unmapped channels read zero
  always_comb begin
    ld_word = 32'd0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch == 4'(k)) ld_word = ch_flat[32*k +: 32];
    end
`ifdef OUTBUF_BLINK_EN
    if (mask_hit) ld_word = mask_q;
`endif
  end

  // Channel registers: apply the decoded op on the enabled lanes of the addressed channel
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ch_flat <= '0;
    end else if (st_fire && ch_hit) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch == 4'(k)) ch_flat[32*k +: 32] <= apply_op(op, ch_flat[32*k +: 32], st_data, st_be);
      end
    end
  end

  // Registered load response and misalign pulse; loads see the pre-store value
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rdata    <= 32'd0;
      o_rvalid   <= 1'b0;
      o_misalign <= 1'b0;
    end else begin
      o_rvalid   <= i_rden;
      o_misalign <= (i_wren & mapped & st_illegal) | (i_rden & mapped & ld_illegal);
      if (i_rden) o_rdata <= mapped ? ld_ext : 32'd0;
    end
  end

  assign o_ch_data = ch_flat & ~{NUM_CH{blink_kill}};

endmodule

// File: tb/tb_mmio_out_bank.sv
// tb/tb_mmio_out_bank.sv - directed scoreboard bench for mmio_out_bank
module tb_mmio_out_bank;
  import mmio_pkg::*;

  localparam int NCH = 5;

  logic               clk;
  logic               rst_n;
  logic               wren;
  logic               rden;
  logic [2:0]         func3;
  logic [31:0]        addr;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               rvalid;
  logic               misalign;
  logic [NCH*32-1:0]  ch_data;
  logic               blink_phase;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          n_edges;

  mmio_out_bank #(.NUM_CH(NCH), .BLINK_DIV(4)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_wren        (wren),
    .i_rden        (rden),
    .i_func3       (func3),
    .i_addr        (addr),
    .i_wdata       (wdata),
    .o_rdata       (rdata),
    .o_rvalid      (rvalid),
    .o_misalign    (misalign),
    .o_ch_data     (ch_data),
    .o_blink_phase (blink_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n_edges <= 0;
    else        n_edges <= n_edges + 1;
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic mis_exp);
    @(posedge clk);
    #1;
    wren = 1'b0;
    rden = 1'b0;
    chk1("misalign", misalign, mis_exp);
    if (exp_q.size() > 0) begin
      chk1("rvalid", rvalid, 1'b1);
      chk32("rdata", rdata, exp_q.pop_front());
    end else begin
      chk1("rvalid_idle", rvalid, 1'b0);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d, input logic mis);
    wren = 1'b1; addr = a; func3 = f3; wdata = d;
    tick(mis);
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] exp, input logic mis);
    rden = 1'b1; addr = a; func3 = f3;
    exp_q.push_back(exp);
    tick(mis);
  endtask

  task automatic ch_is(input string tag, input int k, input logic [31:0] exp);
    chk32(tag, ch_data[32*k +: 32], exp);
  endtask

  initial begin
    rst_n = 1'b0; wren = 1'b0; rden = 1'b0; func3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NCH; k++) ch_is($sformatf("rst_ch%0d", k), k, 32'h0);
    chk32("rst_rdata", rdata, 32'h0);
    chk1("rst_rvalid", rvalid, 1'b0);
    chk1("rst_misalign", misalign, 1'b0);
    chk1("rst_phase", blink_phase, 1'b0);
    rst_n = 1'b1;
    tick(1'b0);

    // word store then load back
    store(32'h0000_2000, F3_SW, 32'h1234_5678, 1'b0);
    ch_is("sw_ch2", 2, 32'h1234_5678);
    load(32'h0000_2000, F3_LW, 32'h1234_5678, 1'b0);

    // byte store into lane 2 and sign/zero-extended loads
    store(32'h0000_1000, F3_SW, 32'hFFFF_0000, 1'b0);
    store(32'h0000_1002, F3_SB, 32'h0000_00A5, 1'b0);
    ch_is("sb_ch1", 1, 32'hFFA5_0000);
    load(32'h0000_1002, F3_LB,  32'hFFFF_FFA5, 1'b0);
    load(32'h0000_1002, F3_LBU, 32'h0000_00A5, 1'b0);
    load(32'h0000_1002, F3_LHU, 32'h0000_FFA5, 1'b0);

    // set / clear / toggle on channel 0
    store(32'h0000_0000, F3_SW, 32'h0000_000F, 1'b0);
    store(32'h0000_0400, F3_SW, 32'h0000_00F0, 1'b0);
    ch_is("set_ch0", 0, 32'h0000_00FF);
    store(32'h0000_0800, F3_SW, 32'h0000_0003, 1'b0);
    ch_is("clr_ch0", 0, 32'h0000_00FC);
    store(32'h0000_0C00, F3_SW, 32'h0000_00FF, 1'b0);
    ch_is("tgl_ch0", 0, 32'h0000_0003);

    // misaligned and illegal accesses
    store(32'h0000_0002, F3_SW, 32'hDEAD_BEEF, 1'b1);
    ch_is("mis_sw_ch0", 0, 32'h0000_0003);
    store(32'h0000_0001, F3_SH, 32'hBEEF, 1'b1);
    store(32'h0000_0000, 3'b011, 32'hFFFF_FFFF, 1'b1);
    ch_is("mis_f3_ch0", 0, 32'h0000_0003);
    load(32'h0000_0002, F3_LW, 32'h0, 1'b1);
    load(32'h0000_0003, F3_LH, 32'h0, 1'b1);
    load(32'h0000_0000, 3'b110, 32'h0, 1'b1);
    tick(1'b0);

    // unmapped channel: store ignored, load zero, no misalign
    store(32'h0000_7000, F3_SW, 32'hAAAA_5555, 1'b0);
    load(32'h0000_7000, F3_LW, 32'h0, 1'b0);
    for (int k = 0; k < NCH; k++) chk1($sformatf("unmapped_ch%0d", k), ch_data[32*k +: 32] == 32'hAAAA_5555, 1'b0);

    // simultaneous store and load return the pre-store value
    store(32'h0000_3000, F3_SW, 32'h0000_0011, 1'b0);
    wren = 1'b1; rden = 1'b1; addr = 32'h0000_3000; func3 = F3_SW; wdata = 32'h0000_0055;
    exp_q.push_back(32'h0000_0011);
    tick(1'b0);
    ch_is("rw_ch3", 3, 32'h0000_0055);

    // halfword and byte ops on upper/middle lanes of channel 1
    store(32'h0000_1002, F3_SH, 32'h0000_1234, 1'b0);
    ch_is("sh_ch1", 1, 32'h1234_0000);
    store(32'h0000_1401, F3_SB, 32'h0000_000F, 1'b0);
    ch_is("setb_ch1", 1, 32'h1234_0F00);
    store(32'h0000_1800, F3_SH, 32'h0000_0F00, 1'b0);
    ch_is("clrh_ch1", 1, 32'h1234_0000);
    store(32'h0000_1C03, F3_SB, 32'h0000_0080, 1'b0);
    ch_is("tglb_ch1", 1, 32'h9234_0000);
    load(32'h0000_1002, F3_LH, 32'hFFFF_9234, 1'b0);
    load(32'h0000_1003, F3_LHU, 32'h0, 1'b1);

    // last channel
    store(32'h0000_4000, F3_SW, 32'hCAFE_F00D, 1'b0);
    load(32'h0000_4000, F3_LW, 32'hCAFE_F00D, 1'b0);
    ch_is("last_ch4", 4, 32'hCAFE_F00D);

`ifdef OUTBUF_BLINK_EN
    // blink mask at channel NUM_CH masks ch2 low byte in the high phase
    store(32'h0000_2000, F3_SW, 32'hFFFF_FFFF, 1'b0);
    store(32'h0000_5000, F3_SW, 32'h0000_00FF, 1'b0);
    load(32'h0000_5000, F3_LW, 32'h0000_00FF, 1'b0);
    for (int i = 0; i < 12; i++) begin
      chk1("blink_phase", blink_phase, 1'(((n_edges / 4) % 2)));
      ch_is("blink_ch2", 2, (((n_edges / 4) % 2) == 1) ? 32'hFFFF_FF00 : 32'hFFFF_FFFF);
      tick(1'b0);
    end
`else
    // channel NUM_CH is unmapped without the blink feature
    store(32'h0000_5000, F3_SW, 32'h0000_00FF, 1'b0);
    load(32'h0000_5000, F3_LW, 32'h0, 1'b0);
    chk1("noblink_phase", blink_phase, 1'b0);
`endif

    // asynchronous reset mid-cycle with a load in flight
    rden = 1'b1; addr = 32'h0000_4000; func3 = F3_LW;
    #3;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NCH; k++) ch_is($sformatf("arst_ch%0d", k), k, 32'h0);
    chk32("arst_rdata", rdata, 32'h0);
    chk1("arst_rvalid", rvalid, 1'b0);
    chk1("arst_phase", blink_phase, 1'b0);
    @(posedge clk);
    #1;
    rden = 1'b0;
    chk1("arst_inflight_rvalid", rvalid, 1'b0);
    chk1("arst_misalign", misalign, 1'b0);
    chk32("arst_rdata_hold", rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
